// File: rtl/spi_loader_pkg.sv
// Shared constants and state encoding for the SPI frame loader.
// SPI_LOADER_CHECKSUM_EN adds a trailing checksum word and the CSUM state.
package spi_loader_pkg;

  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_RESET = 4'h2;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int CNT_MSB = 11;
  localparam int CNT_LSB = 0;
  localparam int CNT_W   = CNT_MSB - CNT_LSB + 1;

  // state       | meaning
  // ST_IDLE     | no frame, waiting for frame_start
  // ST_CMD      | expecting command word
  // ST_ADDR     | expecting start address
  // ST_DATA     | expecting data words, pushed to the write FIFO
  // ST_CSUM     | expecting checksum word
  // ST_WAIT_END | frame body complete, waiting for frame_end
  // ST_DRAIN    | frame closed, waiting for FIFO to empty
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_ADDR     = 3'd2,
    ST_DATA     = 3'd3,
`ifdef SPI_LOADER_CHECKSUM_EN
    ST_CSUM     = 3'd4,
`endif
    ST_WAIT_END = 3'd5,
    ST_DRAIN    = 3'd6
  } state_t;

endpackage

// File: rtl/spi_loader_fifo.sv
// Write buffer between the frame parser and the memory port.
// A push while full is accepted only if a pop happens on the same edge.
module spi_loader_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spi_loader.sv
// Command/address/data frame parser feeding buffered memory writes and CPU hold/reset.
// SPI_LOADER_CHECKSUM_EN enables the trailing checksum word and err_checksum.
module spi_loader
  import spi_loader_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  word,
  input  logic              word_valid,
  input  logic              frame_start,
  input  logic              frame_end,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              cpu_hold,
  output logic              cpu_reset_req,
  output logic              done,
  output logic              err_short,
  output logic              err_long,
  output logic              err_overflow,
  output logic              err_opcode
`ifdef SPI_LOADER_CHECKSUM_EN
  ,
  output logic              err_checksum
`endif
);

`ifdef SPI_LOADER_CHECKSUM_EN
  localparam state_t DATA_NEXT = ST_CSUM;
`else
  localparam state_t DATA_NEXT = ST_WAIT_END;
`endif

  state_t                   state, next_state;
  logic [CNT_W-1:0]         cnt;
  logic [ADDR_W-1:0]        addr;
  logic [3:0]               opcode;
  logic                     in_body;
  logic                     load_cnt, load_addr, push;
  logic                     set_short, set_long, set_opc, reset_hit;
  logic                     fifo_full, fifo_empty, pop;
  logic [ADDR_W+WIDTH-1:0]  fifo_rdata;

  assign opcode = word[OPC_MSB:OPC_LSB];
  assign in_body = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA)
`ifdef SPI_LOADER_CHECKSUM_EN
                   || (state == ST_CSUM)
`endif
                   ;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_cnt   = 1'b0;
    load_addr  = 1'b0;
    push       = 1'b0;
    set_short  = 1'b0;
    set_long   = 1'b0;
    set_opc    = 1'b0;
    reset_hit  = 1'b0;
    case (state)
      ST_CMD: if (word_valid) begin
        load_cnt = 1'b1;
        if (opcode == OP_WRITE) begin
          next_state = ST_ADDR;
        end else begin
          next_state = ST_WAIT_END;
          reset_hit  = (opcode == OP_RESET);
          set_opc    = (opcode != OP_RESET);
        end
      end
      ST_ADDR: if (word_valid) begin
        load_addr  = 1'b1;
        next_state = (cnt == '0) ? DATA_NEXT : ST_DATA;
      end
      ST_DATA: if (word_valid) begin
        push = 1'b1;
        if (cnt == CNT_W'(1)) next_state = DATA_NEXT;
      end
`ifdef SPI_LOADER_CHECKSUM_EN
      ST_CSUM: if (word_valid) next_state = ST_WAIT_END;
`endif
      ST_WAIT_END: begin
        set_long = word_valid;
        if (frame_end) next_state = ST_DRAIN;
      end
      ST_DRAIN: if (fifo_empty) next_state = ST_IDLE;
      default: ;
    endcase
    // frame_end is applied before frame_start when both arrive together
    if (frame_end && in_body) begin
      set_short  = 1'b1;
      next_state = ST_DRAIN;
    end
    if (frame_start) next_state = ST_CMD;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt           <= '0;
      addr          <= '0;
      cpu_reset_req <= 1'b0;
      err_short     <= 1'b0;
      err_long      <= 1'b0;
      err_overflow  <= 1'b0;
      err_opcode    <= 1'b0;
    end else begin
      cpu_reset_req <= reset_hit;
      if (load_cnt)  cnt <= word[CNT_MSB:CNT_LSB];
      else if (push) cnt <= cnt - CNT_W'(1);
      // dropped words still advance the address
      if (load_addr) addr <= ADDR_W'(word);
      else if (push) addr <= addr + ADDR_W'(1);
      if (frame_start) begin
        err_short    <= 1'b0;
        err_long     <= 1'b0;
        err_overflow <= 1'b0;
        err_opcode   <= 1'b0;
      end else begin
        err_short    <= err_short | set_short;
        err_long     <= err_long | set_long;
        err_overflow <= err_overflow | (push && fifo_full && !pop);
        err_opcode   <= err_opcode | set_opc;
      end
    end
  end

`ifdef SPI_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] csum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum         <= '0;
      err_checksum <= 1'b0;
    end else begin
      if (load_addr) csum <= word;
      else if (push) csum <= csum + word;
      if (frame_start)
        err_checksum <= 1'b0;
      else if (state == ST_CSUM && word_valid && word != csum)
        err_checksum <= 1'b1;
    end
  end
`endif

  spi_loader_fifo #(.DEPTH(FIFO_DEPTH), .W(ADDR_W + WIDTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (push),
    .wdata ({addr, word}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign mem_we    = !fifo_empty;
  assign pop       = mem_we && mem_ready;
  assign mem_addr  = fifo_empty ? '0 : fifo_rdata[ADDR_W+WIDTH-1:WIDTH];
  assign mem_wdata = fifo_empty ? '0 : fifo_rdata[WIDTH-1:0];
  assign cpu_hold  = (state != ST_IDLE) || !fifo_empty;
  assign done      = (state == ST_DRAIN) && fifo_empty && !frame_start;

endmodule

// File: tb/tb_spi_loader.sv
// Randomized bench for spi_loader against a queue-based frame model.
module tb_spi_loader;

  localparam int DEPTH = 2;
`ifdef SPI_LOADER_CHECKSUM_EN
  localparam int AFTER_DATA = 3;
`else
  localparam int AFTER_DATA = 4;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] word;
  logic        word_valid, frame_start, frame_end, mem_ready;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_we, cpu_hold, cpu_reset_req, done;
  logic        err_short, err_long, err_overflow, err_opcode;
`ifdef SPI_LOADER_CHECKSUM_EN
  logic        err_checksum;
`endif

  spi_loader #(.WIDTH(16), .ADDR_W(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .word(word), .word_valid(word_valid),
    .frame_start(frame_start), .frame_end(frame_end),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready),
    .cpu_hold(cpu_hold), .cpu_reset_req(cpu_reset_req), .done(done),
    .err_short(err_short), .err_long(err_long), .err_overflow(err_overflow),
    .err_opcode(err_opcode)
`ifdef SPI_LOADER_CHECKSUM_EN
    , .err_checksum(err_checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 0;
  int ready_mode = 0;
  int dut_done = 0;
  int dut_rst = 0;

  // requests from the driver telling the model what each driven cycle means
  bit          req_push, req_short, req_long, req_opc, req_rst, req_csum;
  logic [31:0] req_ent;

  // model state
  logic [31:0] q[$];
  logic [31:0] wlog[$];
  logic [15:0] frame_q[$];
  bit busy, draining, e_short, e_long, e_ovf, e_opc, e_rst, e_csum;
  bit m_pop, m_dn;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: mem_ready = 1'b1;
        1: mem_ready = 1'b0;
        default: mem_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      busy = 0; draining = 0; e_rst = 0;
      e_short = 0; e_long = 0; e_ovf = 0; e_opc = 0; e_csum = 0;
    end else begin
      m_dn = draining && q.size() == 0;
      if (m_dn) begin
        draining = 0;
        busy = 0;
      end
      m_pop = q.size() != 0 && mem_ready;
      e_rst = req_rst;
      if (m_pop) begin
        wlog.push_back(q[0]);
        void'(q.pop_front());
      end
      if (req_push) begin
        if (q.size() < DEPTH) q.push_back(req_ent);
        else e_ovf = 1;
      end
      if (req_long) e_long = 1;
      if (req_opc) e_opc = 1;
      if (req_csum) e_csum = 1;
      if (frame_end) begin
        if (req_short) e_short = 1;
        draining = 1;
      end
      if (frame_start) begin
        busy = 1; draining = 0;
        e_short = 0; e_long = 0; e_ovf = 0; e_opc = 0; e_csum = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && chk_en) begin
      chk("mem_we", 32'(mem_we), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("mem_addr", 32'(mem_addr), 32'(q[0][31:16]));
        chk("mem_wdata", 32'(mem_wdata), 32'(q[0][15:0]));
      end
      chk("cpu_hold", 32'(cpu_hold), 32'(busy || q.size() != 0));
      chk("done", 32'(done), 32'(draining && q.size() == 0));
      chk("cpu_reset_req", 32'(cpu_reset_req), 32'(e_rst));
      chk("err_short", 32'(err_short), 32'(e_short));
      chk("err_long", 32'(err_long), 32'(e_long));
      chk("err_overflow", 32'(err_overflow), 32'(e_ovf));
      chk("err_opcode", 32'(err_opcode), 32'(e_opc));
`ifdef SPI_LOADER_CHECKSUM_EN
      chk("err_checksum", 32'(err_checksum), 32'(e_csum));
`endif
      if (done) dut_done++;
      if (cpu_reset_req) dut_rst++;
    end
  end

  task automatic clear_req();
    req_push = 0; req_short = 0; req_long = 0; req_opc = 0; req_rst = 0; req_csum = 0;
  endtask

  // walks frame_q by its meaning in the frame and tags each word for the model
  task automatic send_frame(input int gap_max);
    int mode, rem;
    logic [15:0] w, a_m, s_m;
    mode = 0; rem = 0; a_m = '0; s_m = '0;
    frame_start = 1; cyc(); frame_start = 0;
    foreach (frame_q[i]) begin
      w = frame_q[i];
      case (mode)
        0: begin
          if (w[15:12] == 4'h1) begin mode = 1; rem = int'(w[11:0]); end
          else if (w[15:12] == 4'h2) begin req_rst = 1; mode = 4; end
          else begin req_opc = 1; mode = 4; end
        end
        1: begin a_m = w; s_m = w; mode = (rem == 0) ? AFTER_DATA : 2; end
        2: begin
          req_push = 1; req_ent = {a_m, w};
          a_m = a_m + 16'd1; s_m = s_m + w; rem--;
          if (rem == 0) mode = AFTER_DATA;
        end
        3: begin req_csum = (w != s_m); mode = 4; end
        default: req_long = 1;
      endcase
      word = w; word_valid = 1; cyc(); word_valid = 0; clear_req();
      repeat ($urandom_range(0, gap_max)) cyc();
    end
    req_short = (mode != 4);
    frame_end = 1; cyc(); frame_end = 0; req_short = 0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 400; i++) begin
      if (!cpu_hold) break;
      cyc();
    end
    if (i == 400) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle: cpu_hold still %b after 400 cycles", cpu_hold);
    end
    cyc();
  endtask

  task automatic build_random();
    int r, cnt;
    logic [3:0] op;
    logic [15:0] a, s, d;
    frame_q.delete();
    r = $urandom_range(0, 9);
    if (r == 0) frame_q.push_back({4'h2, 12'($urandom_range(0, 4095))});
    else if (r == 1) begin
      op = 4'($urandom_range(0, 13));
      if (op >= 4'd1) op = op + 4'd2;
      frame_q.push_back({op, 12'($urandom_range(0, 4095))});
    end else begin
      cnt = $urandom_range(0, 5);
      frame_q.push_back({4'h1, 12'(cnt)});
      a = 16'($urandom); s = a;
      frame_q.push_back(a);
      for (int k = 0; k < cnt; k++) begin
        d = 16'($urandom); s = s + d;
        frame_q.push_back(d);
      end
`ifdef SPI_LOADER_CHECKSUM_EN
      frame_q.push_back(($urandom_range(0, 3) == 0) ? s ^ 16'h0001 : s);
`endif
    end
    if ($urandom_range(0, 4) == 0 && frame_q.size() > 1)
      repeat ($urandom_range(1, frame_q.size() - 1)) void'(frame_q.pop_back());
    else if ($urandom_range(0, 4) == 0)
      frame_q.push_back(16'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0;
    reset_n = 0; word = '0; word_valid = 0; frame_start = 0; frame_end = 0;
    req_ent = '0; clear_req();
    repeat (3) cyc();
    chk("rst mem_we", 32'(mem_we), 0);
    chk("rst cpu_hold", 32'(cpu_hold), 0);
    chk("rst done", 32'(done), 0);
    chk("rst errs", {28'd0, err_short, err_long, err_overflow, err_opcode}, 0);
    reset_n = 1; chk_en = 1;
    cyc();

    // basic write, memory always ready
    frame_q = '{16'h1003, 16'h0100, 16'hAAAA, 16'hBBBB, 16'hCCCC};
    wlog.delete(); d0 = dut_done;
    send_frame(0); wait_idle();
    chk("t1 nwrites", wlog.size(), 3);
    chk("t1 w0", wlog[0], 32'h0100_AAAA);
    chk("t1 w1", wlog[1], 32'h0101_BBBB);
    chk("t1 w2", wlog[2], 32'h0102_CCCC);
    chk("t1 done", dut_done - d0, 1);

    // memory stalled: third word overflows the 2-entry buffer
    ready_mode = 1;
    wlog.delete(); d0 = dut_done;
    send_frame(0);
    repeat (32) cyc();
    ready_mode = 0;
    wait_idle();
    chk("t2 err_overflow", 32'(err_overflow), 1);
    chk("t2 nwrites", wlog.size(), 2);
    chk("t2 w0", wlog[0], 32'h0100_AAAA);
    chk("t2 w1", wlog[1], 32'h0101_BBBB);
    chk("t2 done", dut_done - d0, 1);

    // address wrap and short frame
    frame_q = '{16'h1004, 16'hFFFF, 16'h1111, 16'h2222};
    wlog.delete(); d0 = dut_done;
    send_frame(1); wait_idle();
    chk("t3 w0", wlog[0], 32'hFFFF_1111);
    chk("t3 w1", wlog[1], 32'h0000_2222);
    chk("t3 err_short", 32'(err_short), 1);
    chk("t3 done", dut_done - d0, 1);

    // reset command followed by a surplus word
    frame_q = '{16'h2000, 16'h1234};
    r0 = dut_rst;
    send_frame(1); wait_idle();
    chk("t4 reset pulses", dut_rst - r0, 1);
    chk("t4 err_long", 32'(err_long), 1);

    // bad opcode, then cleared by the next frame
    frame_q = '{16'h7000};
    send_frame(0); wait_idle();
    chk("t5 err_opcode", 32'(err_opcode), 1);
    frame_q = '{16'h1000, 16'h0005};
`ifdef SPI_LOADER_CHECKSUM_EN
    frame_q.push_back(16'h0005);
`endif
    send_frame(0); wait_idle();
    chk("t5 err_opcode cleared", 32'(err_opcode), 0);

`ifdef SPI_LOADER_CHECKSUM_EN
    frame_q = '{16'h1001, 16'h0010, 16'h0005, 16'h0015};
    send_frame(0); wait_idle();
    chk("cs good", 32'(err_checksum), 0);
    frame_q = '{16'h1001, 16'h0010, 16'h0005, 16'h0016};
    wlog.delete();
    send_frame(0); wait_idle();
    chk("cs bad", 32'(err_checksum), 1);
    chk("cs write kept", wlog[0], 32'h0010_0005);
`endif

    // randomized frames with random back-pressure
    ready_mode = 2;
    for (int f = 0; f < 40; f++) begin
      build_random();
      send_frame(2);
      wait_idle();
    end

    // reset asserted while a write is pending
    ready_mode = 1;
    frame_start = 1; cyc(); frame_start = 0;
    word = 16'h1002; word_valid = 1; cyc();
    word = 16'h0040; cyc();
    word = 16'h5555; req_push = 1; req_ent = 32'h0040_5555; cyc();
    word_valid = 0; clear_req(); cyc();
    chk("pre-reset mem_we", 32'(mem_we), 1);
    #2 reset_n = 0;
    #1;
    chk("mid-reset mem_we", 32'(mem_we), 0);
    chk("mid-reset cpu_hold", 32'(cpu_hold), 0);
    cyc(); cyc();
    reset_n = 1; ready_mode = 0;
    cyc();
    frame_q = '{16'h1001, 16'h0200, 16'h1357};
`ifdef SPI_LOADER_CHECKSUM_EN
    frame_q.push_back(16'h1557);
`endif
    wlog.delete();
    send_frame(0); wait_idle();
    chk("post-reset nwrites", wlog.size(), 1);
    chk("post-reset w0", wlog[0], 32'h0200_1357);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_loader.md
# spi_loader

Frame parser that sits directly downstream of the SPI slave receiver. It consumes each completed 16-bit word together with the frame-start and frame-end strobes, and decodes a command/address/data frame. It turns data words into memory write transactions toward the CPU memory port, buffered through a small FIFO so memory back-pressure never stalls the SPI link. It also issues CPU hold and CPU reset requests so the host can load and restart the Forth CPU over SPI.

## Interface
- WIDTH, 16, SPI word width; must match the receiver width.
- ADDR_W, 16, memory address width.
- FIFO_DEPTH, 4, write-buffer entries; power of two, at least 2.

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  system clock, same domain as the SPI receiver.
- reset_n  in  1  asynchronous active-low reset.
- word  in  WIDTH  received word; valid only while word_valid is high.
- word_valid  in  1  one-cycle strobe, one per received word.
- frame_start  in  1  one-cycle strobe when chip select falls.
- frame_end  in  1  one-cycle strobe when chip select rises.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  WIDTH  write data.
- mem_we  out  1  write request; held until accepted.
- mem_ready  in  1  memory accepts the write when mem_we and mem_ready are both high.
- cpu_hold  out  1  high while a frame is being parsed or writes are pending.
- cpu_reset_req  out  1  one-cycle pulse from a RESET command.
- done  out  1  one-cycle pulse when a frame completes and all its writes have drained.
- err_short, err_long, err_overflow, err_opcode  out  1 each  sticky error flags.

## Operation
- Command word: opcode is word[15:12], count is word[11:0] (number of data words, 0 allowed).
- Opcode 0x1 (WRITE): the next word is the start address (zero-extended or truncated to ADDR_W). Each of the following count words is pushed to the FIFO as an {addr, data} entry; addr increments by 1 per word and wraps modulo 2^ADDR_W.
- Opcode 0x2 (RESET): pulse cpu_reset_req in the cycle after the command word. Count is ignored.
- Any other opcode: set err_opcode and go to WAIT_END.
- States and transitions:
  - IDLE: frame_start → CMD.
  - CMD: word → ADDR (WRITE) or WAIT_END (RESET or bad opcode).
  - ADDR: word → DATA, or → CSUM/WAIT_END if count is 0.
  - DATA: the count-th word → CSUM (macro enabled) or WAIT_END.
  - CSUM: word → WAIT_END.
  - WAIT_END: frame_end → DRAIN.
  - DRAIN: FIFO empty → IDLE and pulse done.
- frame_end in CMD, ADDR, DATA or CSUM: set err_short and go to DRAIN. FIFO entries already pushed still drain.
- A word arriving in WAIT_END is dropped and sets err_long.
- Words arriving in IDLE or DRAIN are ignored; no flag.
- frame_start in any state: clear all error flags and go to CMD.
  - The FIFO is never flushed.
  - If frame_start arrives in DRAIN, the pending done pulse is dropped.
- FIFO full when a data word arrives: the word is dropped, err_overflow is set, and the address still increments.
- frame_start and frame_end in the same cycle: frame_end is applied first, then frame_start.
- cpu_hold = (state != IDLE) or (FIFO not empty).

## Timing
- Reset: state IDLE, FIFO empty, every output 0.
- A data word with word_valid at cycle t reaches mem_we by cycle t+1 if the FIFO was empty.
- mem_addr and mem_wdata are stable while mem_we is high and mem_ready is low.
- The FIFO pops on the same edge a write is accepted. The next entry is presented in the following cycle; full throughput is one write per cycle.
- A push and a pop in the same cycle are both allowed, including when the FIFO is full.
- done is asserted in the cycle after the last write is accepted while in DRAIN, or in the cycle after entering DRAIN if the FIFO is already empty.
- Reset asserted mid-frame: everything returns to reset values immediately and pending writes are discarded.

## Configuration
- Macro: SPI_LOADER_CHECKSUM_EN.
- Defined:
  - WRITE frames carry one extra final word, equal to the 16-bit modulo sum of the address word and all data words.
  - A mismatch sets an additional sticky output err_checksum (reset 0, cleared on frame_start).
  - Writes are not suppressed on mismatch.
- Undefined: there is no CSUM state, no err_checksum port, and no checksum adder.

## Structure
- Package spi_loader_pkg: opcode constants (OP_WRITE = 4'h1, OP_RESET = 4'h2), the state enum, and the command field bit positions.
- Sub-module spi_loader_fifo: synchronous FIFO of depth FIFO_DEPTH and width ADDR_W+WIDTH with full/empty flags and simultaneous push/pop.

## Test plan
- Words 0x1003, 0x0100, 0xAAAA, 0xBBBB, 0xCCCC with mem_ready=1 → writes (0x0100, AAAA), (0x0101, BBBB), (0x0102, CCCC), then one done pulse after frame_end.
- Same frame with mem_ready held low for 40 cycles, FIFO_DEPTH=2 and words arriving 1 cycle apart → err_overflow set; surviving writes land at the correct addresses; done pulses after the drain.
- Words 0x1004, 0xFFFF, then 2 data words and frame_end → writes to 0xFFFF and 0x0000 (address wraps); err_short set; done still pulses.
- Word 0x2000 → cpu_reset_req pulses exactly once. A following 0x1234 in the same frame sets err_long.
- Word 0x7000 → err_opcode set. The next frame_start clears it.
- With SPI_LOADER_CHECKSUM_EN: 0x1001, 0x0010, 0x0005, 0x0015 → no error. Last word 0x0016 → err_checksum set, and the write to 0x0010 still occurs.
